// File: rtl/vga_capture.sv
// VGA receive-side capture: locks to sync timing, rebuilds pixel coordinates,
// checks line/frame lengths and sums each frame, with a small CPU-bus register file.
module vga_capture #(
  parameter int H_VISIBLE = 640,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 480,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int V_TOTAL   = 525,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [3:0]        Red,
  input  logic [3:0]        Green,
  input  logic [3:0]        Blue,
  output logic              cap_valid,
  output logic [9:0]        cap_x,
  output logic [9:0]        cap_y,
  output logic [11:0]       cap_rgb,
  output logic              frame_done,
  input  logic              valid,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready
);

  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_nxt;
  logic          hs_q, vs_q;
  logic [HW-1:0] h_cnt, h_pos, h_inc;
  logic [VW-1:0] v_cnt, v_pos, v_lines;
  logic [31:0]   acc, frame_sum, pix_add;
  logic [15:0]   frame_cnt;
  logic          h_err, v_err, en;
  logic          h_fall, v_fall, set_h, set_v, frame_ok, visible;
  logic [11:0]   rgb;
  logic          req, wr;
  logic [DATA_W-1:0] rd_mux;
  logic          unused_bits;

  assign rgb     = {Red, Green, Blue};
  assign h_fall  = pix_en & hs_q & ~h_sync;
  assign v_fall  = pix_en & vs_q & ~v_sync;
  assign h_inc   = h_cnt + 1'b1;
  assign v_lines = h_fall ? v_cnt + 1'b1 : v_cnt;
  assign pix_add = visible ? 32'(rgb) : 32'd0;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    h_pos     = h_cnt;
    v_pos     = v_cnt;
    set_h     = 1'b0;
    set_v     = 1'b0;
    frame_ok  = 1'b0;
    if (!en) begin
      state_nxt = SEARCH;
    end else if (pix_en) begin
      case (state)
        SEARCH: if (v_fall) begin
          state_nxt = LOCKED;
          h_pos     = '0;
          v_pos     = '0;
        end
        LOCKED: begin
          h_pos = h_inc;
          if (h_fall && h_inc != HW'(H_TOTAL)) begin
            set_h     = 1'b1;
            state_nxt = SEARCH;
          end else if (v_fall) begin
            h_pos = '0;
            v_pos = '0;
            if (v_lines != VW'(V_TOTAL)) begin
              set_v     = 1'b1;
              state_nxt = SEARCH;
            end else begin
              frame_ok = 1'b1;
            end
          end else if (h_fall) begin
            h_pos = '0;
            v_pos = v_lines;
            // A frame running past V_TOTAL lines with no vsync is also a length error.
            if (v_lines >= VW'(V_TOTAL)) begin
              set_v     = 1'b1;
              state_nxt = SEARCH;
            end
          end else if (h_inc == HW'(H_TOTAL)) begin
            set_h     = 1'b1;
            state_nxt = SEARCH;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  assign visible = en && pix_en && state == LOCKED && state_nxt == LOCKED &&
                   h_pos >= HW'(H_START) && h_pos < HW'(H_START + H_VISIBLE) &&
                   v_pos >= VW'(V_START) && v_pos < VW'(V_START + V_VISIBLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      acc        <= '0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
      cap_valid  <= 1'b0;
      cap_x      <= '0;
      cap_y      <= '0;
      cap_rgb    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (pix_en) begin
        hs_q <= h_sync;
        vs_q <= v_sync;
      end
      state      <= state_nxt;
      h_cnt      <= h_pos;
      v_cnt      <= v_pos;
      cap_valid  <= visible;
      frame_done <= frame_ok;
      if (visible) begin
        cap_x   <= 10'(h_pos - HW'(H_START));
        cap_y   <= 10'(v_pos - VW'(V_START));
        cap_rgb <= rgb;
      end
      if (frame_ok) begin
        frame_sum <= acc + pix_add;
        frame_cnt <= frame_cnt + 1'b1;
        acc       <= '0;
      end else if (state == SEARCH && state_nxt == LOCKED) begin
        acc <= '0;
      end else if (visible) begin
        acc <= acc + pix_add;
      end
    end
  end

  assign req = valid & ~ready;
  assign wr  = req & (wstrb != 4'b0000);

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0: rd_mux = DATA_W'({state == LOCKED, v_err, h_err});
      2'd1: rd_mux = DATA_W'(frame_cnt);
      2'd2: rd_mux = DATA_W'(frame_sum);
      2'd3: rd_mux = DATA_W'(en);
      default: rd_mux = '0;
    endcase
  end

  // A fresh error in the same cycle as its W1C clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
      h_err <= 1'b0;
      v_err <= 1'b0;
      en    <= 1'b1;
    end else begin
      ready <= req;
      if (req) rdata <= wr ? '0 : rd_mux;
      h_err <= (h_err & ~(wr & addr == 2'd0 & wstrb[0] & wdata[0])) | set_h;
      v_err <= (v_err & ~(wr & addr == 2'd0 & wstrb[0] & wdata[1])) | set_v;
      if (wr && addr == 2'd3 && wstrb[0]) en <= wdata[0];
    end
  end

  assign unused_bits = ^wdata[DATA_W-1:2];

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 16x10 raster so whole frames stay short.
module tb_vga_capture;

  localparam int H_VISIBLE = 8;
  localparam int H_SYNC    = 2;
  localparam int H_BP      = 2;
  localparam int H_TOTAL   = 16;
  localparam int V_VISIBLE = 4;
  localparam int V_SYNC    = 1;
  localparam int V_BP      = 2;
  localparam int V_TOTAL   = 10;
  localparam int H_START   = H_SYNC + H_BP;
  localparam int V_START   = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [3:0]  Red = '0, Green = '0, Blue = '0;
  logic        cap_valid, frame_done, ready;
  logic [9:0]  cap_x, cap_y;
  logic [11:0] cap_rgb;
  logic        valid = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cap_total = 0, done_total = 0, cap_mark = 0;
  logic [9:0]  first_x, first_y, last_x, last_y;
  logic [11:0] first_rgb, last_rgb;

  vga_capture #(
    .H_VISIBLE(H_VISIBLE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_VISIBLE(V_VISIBLE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
    .Red(Red), .Green(Green), .Blue(Blue),
    .cap_valid(cap_valid), .cap_x(cap_x), .cap_y(cap_y), .cap_rgb(cap_rgb),
    .frame_done(frame_done),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_valid) begin
      if (cap_total == cap_mark) begin
        first_x = cap_x; first_y = cap_y; first_rgb = cap_rgb;
      end
      last_x = cap_x; last_y = cap_y; last_rgb = cap_rgb;
      cap_total++;
    end
    if (frame_done) done_total++;
  end

  task automatic send_pixel(input logic hs, input logic vs, input logic [11:0] c);
    @(negedge clk);
    h_sync = hs; v_sync = vs; {Red, Green, Blue} = c; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int lines, input int short_line, input bit grad,
                            input logic [11:0] color);
    logic [11:0] c;
    int len;
    for (int l = 0; l < lines; l++) begin
      len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int h = 0; h < len; h++) begin
        c = color;
        if (grad) c = (h >= H_START && h < H_START + H_VISIBLE) ? 12'(h - H_START) : 12'h000;
        send_pixel(h >= H_SYNC, l >= V_SYNC, c);
      end
    end
  endtask

  task automatic bus_xfer(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 8);
    rd = rdata;
    valid = 1'b0; wstrb = '0;
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_timeout: no ready after %0d clk, required 1", lat);
    end
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    int lat;
    bus_xfer(a, 32'h0, 4'h0, d, lat);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    int lat;
    logic [31:0] rd;
    bus_xfer(a, d, 4'h1, rd, lat);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #3;
    n_cmp++;
    if ({cap_valid, frame_done, ready, cap_x, cap_y, cap_rgb, rdata} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %0h, required 0", d); end
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0h, required 0", d); end
    bus_rd(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_frame_sum: got %0h, required 0", d); end
    bus_rd(2'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL reset_ctrl: got %0h, required 1", d); end
  endtask

  task automatic test_bus;
    logic [31:0] d;
    int lat;
    bus_xfer(2'd0, 32'h0, 4'h0, d, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL bus_latency: got %0d clk, required 1", lat); end
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL bus_ready_pulse: got %b, required 0", ready); end
    bus_xfer(2'd1, 32'hFFFF, 4'hF, d, lat);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL bus_write_rdata: got %0h, required 0", d); end
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ro_write_ignored: got %0h, required 0", d); end
  endtask

  task automatic test_frames;
    logic [31:0] d;
    int done_base;
    for (int i = 0; i < 4; i++) send_pixel(1'b1, 1'b1, 12'h000);
    done_base = done_total;
    for (int f = 0; f < 3; f++) send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    n_cmp++; if (done_total - done_base !== 2) begin
      n_bad++; $display("FAIL frame_done_count: got %0d, required 2", done_total - done_base);
    end
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL frame_cnt: got %0d, required 2", d); end
    bus_rd(2'd2, d);
    n_cmp++; if (d !== 32'd9312) begin n_bad++; $display("FAIL frame_sum: got %0d, required 9312", d); end
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL status_locked: got %0h, required 4", d); end
  endtask

  task automatic test_gradient;
    int cap_base;
    cap_base = cap_total;
    cap_mark = cap_total;
    send_frame(V_TOTAL, -1, 1'b1, 12'h000);
    n_cmp++; if (cap_total - cap_base !== 32) begin
      n_bad++; $display("FAIL grad_cap_count: got %0d, required 32", cap_total - cap_base);
    end
    n_cmp++; if ({first_x, first_y, first_rgb} !== {10'd0, 10'd0, 12'h000}) begin
      n_bad++; $display("FAIL grad_first: got (%0d,%0d,%0h), required (0,0,0)", first_x, first_y, first_rgb);
    end
    n_cmp++; if ({last_x, last_y, last_rgb} !== {10'd7, 10'd3, 12'h007}) begin
      n_bad++; $display("FAIL grad_last: got (%0d,%0d,%0h), required (7,3,7)", last_x, last_y, last_rgb);
    end
  endtask

  task automatic test_short_line;
    logic [31:0] d;
    int done_base;
    done_base = done_total;
    send_frame(V_TOTAL, 5, 1'b0, 12'h123);
    n_cmp++; if (done_total - done_base !== 1) begin
      n_bad++; $display("FAIL short_line_done: got %0d, required 1", done_total - done_base);
    end
    bus_rd(2'd2, d);
    n_cmp++; if (d !== 32'd112) begin n_bad++; $display("FAIL grad_frame_sum: got %0d, required 112", d); end
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL short_line_cnt: got %0d, required 4", d); end
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL h_err_status: got %0h, required 1", d); end
    done_base = done_total;
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL relock_status: got %0h, required 5", d); end
    n_cmp++; if (done_total - done_base !== 0) begin
      n_bad++; $display("FAIL relock_done: got %0d, required 0", done_total - done_base);
    end
    bus_wr(2'd0, 32'h1);
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL h_err_clear: got %0h, required 4", d); end
  endtask

  task automatic test_short_frame;
    logic [31:0] d;
    send_frame(V_TOTAL - 1, -1, 1'b0, 12'h0FF);
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL v_err_status: got %0h, required 2", d); end
    bus_rd(2'd2, d);
    n_cmp++; if (d !== 32'd9312) begin n_bad++; $display("FAIL v_err_sum_held: got %0d, required 9312", d); end
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL v_err_cnt: got %0d, required 5", d); end
    bus_wr(2'd0, 32'h2);
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL v_err_clear: got %0h, required 0", d); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    int done_base;
    done_base = done_total;
    fork
      send_frame(V_TOTAL, -1, 1'b0, 12'h123);
      begin
        repeat (350) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({cap_valid, frame_done, ready, cap_x, cap_y, cap_rgb, rdata} !== '0) begin
          n_bad++; $display("FAIL mid_reset_outputs: x=%0d y=%0d rgb=%0h, required all 0", cap_x, cap_y, cap_rgb);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    join
    n_cmp++; if (done_total - done_base !== 0) begin
      n_bad++; $display("FAIL mid_reset_done: got %0d, required 0", done_total - done_base);
    end
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_search: got %0h, required 0", d); end
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL post_reset_cnt: got %0d, required 1", d); end
    bus_rd(2'd2, d);
    n_cmp++; if (d !== 32'd9312) begin n_bad++; $display("FAIL post_reset_sum: got %0d, required 9312", d); end
  endtask

  task automatic test_ctrl_en;
    logic [31:0] d;
    int cap_base, done_base;
    bus_wr(2'd3, 32'h0);
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL en0_unlocked: got %0h, required 0", d); end
    cap_base = cap_total;
    done_base = done_total;
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    n_cmp++; if (cap_total - cap_base !== 0) begin
      n_bad++; $display("FAIL en0_captures: got %0d, required 0", cap_total - cap_base);
    end
    n_cmp++; if (done_total - done_base !== 0) begin
      n_bad++; $display("FAIL en0_done: got %0d, required 0", done_total - done_base);
    end
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL en0_cnt_held: got %0d, required 1", d); end
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL ctrl_readback: got %0h, required 1", d); end
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    bus_rd(2'd0, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL en1_relock: got %0h, required 4", d); end
    send_frame(V_TOTAL, -1, 1'b0, 12'h123);
    bus_rd(2'd1, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL en1_cnt: got %0d, required 2", d); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_frames();
    test_gradient();
    test_short_line();
    test_short_frame();
    test_mid_reset();
    test_ctrl_en();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart to the SoC VGA timing generator.
- Samples h_sync, v_sync, Red, Green and Blue on pixel-enable ticks, locks to frame timing and reconstructs pixel_x, pixel_y and rgb as a stream.
- Checks line and frame lengths and keeps a per-frame pixel sum.
- Exposes status and results through a native CPU-bus responder (valid/addr/wdata/wstrb/rdata/ready), so firmware or the bench can self-check video output.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_TOTAL, 800, pixels per line, including porches and sync
- V_VISIBLE, 480, active lines per frame
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_TOTAL, 525, lines per frame
- DATA_W, 32, CPU bus data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pix_en  in  1  pixel tick; all video inputs are sampled only when it is high
- h_sync  in  1  horizontal sync, active-low
- v_sync  in  1  vertical sync, active-low
- Red  in  4  red component
- Green  in  4  green component
- Blue  in  4  blue component
- cap_valid  out  1  captured pixel valid, one clk wide
- cap_x  out  10  captured pixel x
- cap_y  out  10  captured pixel y
- cap_rgb  out  12  captured pixel {Red,Green,Blue}
- frame_done  out  1  one-clk pulse when a good frame completes
- valid  in  1  CPU bus request
- addr  in  2  CPU bus word address
- wdata  in  DATA_W  CPU bus write data
- wstrb  in  4  CPU bus byte strobes; 0 means read
- rdata  out  DATA_W  CPU bus read data
- ready  out  1  CPU bus response

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: all outputs 0; state SEARCH; all counters, sums and error bits 0; CTRL.en = 1.
- Edge detection: registered copies hs_q and vs_q update on pix_en only. A falling edge is prev = 1 and current = 0 at a pix_en sample.
- State SEARCH:
  - Counters idle.
  - On a v_sync falling edge: h_cnt = 0, v_cnt = 0, acc = 0, go to LOCKED.
- State LOCKED, on each pix_en:
  - h_cnt increments.
  - On an h_sync falling edge:
    - if h_cnt + 1 != H_TOTAL: set h_err and go to SEARCH;
    - else h_cnt = 0 and v_cnt increments.
  - On a v_sync falling edge:
    - if v_cnt + 1 != V_TOTAL (counting the coincident h_sync edge): set v_err, go to SEARCH, and FRAME_SUM is not updated;
    - else FRAME_SUM = acc + the current pixel, FRAME_CNT increments, frame_done pulses, then acc = 0, h_cnt = 0, v_cnt = 0.
  - Simultaneous h and v falling edges: the v rule takes priority, and the h length check still applies first.
  - h_cnt reaching H_TOTAL without an h_sync edge sets h_err and returns to SEARCH.
- Visible region:
  - h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VISIBLE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_VISIBLE-1].
  - x = h_cnt - (H_SYNC+H_BP); y = v_cnt - (V_SYNC+V_BP).
- Capture output:
  - For a visible sample in LOCKED with en = 1: cap_valid = 1 one clk after the pix_en sample, with cap_x, cap_y and cap_rgb registered alongside.
  - cap_x, cap_y and cap_rgb hold their value otherwise.
- Accumulator: acc += rgb (zero-extended 12-bit) for each visible pixel, 32-bit unsigned. A full white frame totals 1,257,984,000 and never wraps.
- en = 0: the block forces SEARCH and holds stats.
- CPU bus:
  - ready pulses high exactly one clk after any valid, then returns low; valid is held by the initiator until ready.
  - rdata is valid with ready and is 0 on writes.
- Register map:
  - 0 STATUS: {29'b0, locked, v_err, h_err}. Writing 1 to bit0 or bit1 clears that bit (W1C). If the clear coincides with a new error, the error wins.
  - 1 FRAME_CNT: 16-bit, wraps 0xFFFF -> 0, read-only.
  - 2 FRAME_SUM: read-only.
  - 3 CTRL: bit0 en, read/write. Writes use wstrb[0].
- Writes to read-only registers are ignored.
- Reset mid-frame: everything returns to SEARCH immediately; no frame_done is issued.

Test Plan:
- Three ideal 800x525 frames at pix_en = 1 every 4 clk, constant rgb 0x123:
  - FRAME_CNT = 2 (the first v edge only locks);
  - FRAME_SUM = 89,395,200;
  - one frame_done per completed frame;
  - STATUS = 0x4.
- Gradient rgb = x[11:0] -> cap_valid count = 307,200 per frame; the first capture has (x, y) = (0, 0) and the last has (639, 479), with cap_rgb = x.
- One line of 799 pixels -> h_err = 1, locked = 0, no frame_done; the next v_sync edge relocks; a write of 0x1 to STATUS clears h_err.
- A frame of 524 lines -> v_err = 1 and FRAME_SUM unchanged.
- Assert rst low mid-line -> all outputs 0 asynchronously; on release, state is SEARCH and the next good frame counts normally.
- Bus:
  - read STATUS -> ready exactly one clk after valid;
  - write CTRL = 0 -> no captures and locked = 0;
  - write CTRL = 1 -> relock on the next v_sync edge.
